tsc_adc_arbiter: RTL and testbench

//   Shares one ADC between N_CH transient-capture channels. Each channel keeps the
//   ADC-side req/rdy/dat handshake it already uses. Round-robin grant, one sample
//   per grant, four-phase handshake toward the ADC. Sits between the capture

---
 rtl/tsc_adc_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tsc_adc_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tsc_adc_arbiter.sv
// tsc_adc_arbiter: shares one ADC between N_CH capture channels.
// The arbiter grants channels round-robin, captures one sample per grant, and runs a
// four-phase req/rdy handshake toward the ADC. adc_rdy is asynchronous to clk and
// passes through a 2-flop synchronizer.
// Optional feature: define ADC_TIMEOUT_EN to add the GRANT/WAIT_LOW watchdog and the
// sticky err_timeout flag.
module tsc_adc_arbiter #(
    parameter int N_CH        = 4,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          ch_req,
    output logic [N_CH-1:0]          ch_rdy,
    output logic [DW-1:0]            ch_dat,
    output logic [$clog2(N_CH)-1:0]  grant_id,
    output logic                     busy,
    output logic                     adc_req,
    input  logic                     adc_rdy,
    input  logic [DW-1:0]            adc_dat,
    output logic                     err_timeout
);
    localparam int IW = $clog2(N_CH);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_LOW} state_t;

    state_t          state_q, state_d;
    logic            rdy_meta_q, rdy_s_q;
    logic [IW-1:0]   ptr_q, ptr_d, gid_q, gid_d;
    logic            adc_req_q, adc_req_d;
    logic [N_CH-1:0] ch_rdy_q, ch_rdy_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            err_q, err_d;
    logic            pick_vld;
    logic [IW-1:0]   pick_id;
    logic            tmo;

    // Synchronizer resets to "ready" so that adc_req cannot rise after reset until
    // the ADC has actually been seen low (the ADC may still be mid-handshake).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_meta_q <= 1'b1;
            rdy_s_q    <= 1'b1;
        end else begin
            rdy_meta_q <= adc_rdy;
            rdy_s_q    <= rdy_meta_q;
        end
    end

    // Round-robin pick: lowest index at or after the pointer, wrapping.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % N_CH;
            if (ch_req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = IW'(idx);
            end
        end
    end

`ifdef ADC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign tmo = (cnt_q == CW'(TIMEOUT_CYC));

    // Watchdog counter: restarts on every state change, saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (!tmo)          cnt_d = cnt_q + CW'(1);
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gid_q     <= '0;
            adc_req_q <= 1'b0;
            ch_rdy_q  <= '0;
            dat_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gid_q     <= gid_d;
            adc_req_q <= adc_req_d;
            ch_rdy_q  <= ch_rdy_d;
            dat_q     <= dat_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (pick_vld && !rdy_s_q) state_d = GRANT;
            GRANT:    if (rdy_s_q || tmo)       state_d = WAIT_LOW;
            WAIT_LOW: if (!rdy_s_q)             state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Output/datapath next values; a sample arriving together with the timeout wins.
    always_comb begin
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        adc_req_d = adc_req_q;
        ch_rdy_d  = '0;
        dat_d     = dat_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (pick_vld && !rdy_s_q) begin
                    gid_d     = pick_id;
                    adc_req_d = 1'b1;
                end
            end
            GRANT: begin
                if (rdy_s_q) begin
                    dat_d     = adc_dat;
                    adc_req_d = 1'b0;
                    if (ch_req[gid_q]) ch_rdy_d[gid_q] = 1'b1;
                end else if (tmo) begin
                    err_d     = 1'b1;
                    adc_req_d = 1'b0;
                end
            end
            WAIT_LOW: begin
                if (!rdy_s_q)
                    ptr_d = (gid_q == IW'(N_CH - 1)) ? '0 : gid_q + IW'(1);
                else if (tmo)
                    err_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign ch_rdy      = ch_rdy_q;
    assign ch_dat      = dat_q;
    assign grant_id    = gid_q;
    assign busy        = (state_q != IDLE);
    assign adc_req     = adc_req_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_tsc_adc_arbiter.sv
// Directed bench for tsc_adc_arbiter: ADC model answers 3 cycles after adc_req,
// a monitor logs grants and ch_rdy pulses, one initial block walks the scenarios.
module tb_tsc_adc_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ch_req = '0;
    logic [3:0] ch_rdy;
    logic [7:0] ch_dat;
    logic [1:0] grant_id;
    logic       busy, adc_req, adc_rdy, err_timeout;
    logic [7:0] adc_dat;

    logic       adc_en = 1'b1;
    logic       man_rdy = 1'b0;
    logic       model_rdy = 1'b0;
    logic [7:0] model_dat = 8'hA7;
    int         model_cnt = 0;

    int errors = 0;
    int checks = 0;

    tsc_adc_arbiter #(.N_CH(4), .DW(8), .TIMEOUT_CYC(10)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_rdy(ch_rdy), .ch_dat(ch_dat),
        .grant_id(grant_id), .busy(busy), .adc_req(adc_req), .adc_rdy(adc_rdy),
        .adc_dat(adc_dat), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    assign adc_rdy = adc_en ? model_rdy : man_rdy;
    assign adc_dat = model_dat;

    // ADC model: rdy rises 3 cycles after req is seen, falls once req drops.
    always @(posedge clk) begin
        if (!adc_req) begin
            model_rdy <= 1'b0;
            model_cnt <= 0;
        end else if (model_cnt == 3) begin
            model_rdy <= 1'b1;
        end else begin
            model_cnt <= model_cnt + 1;
        end
    end

    // Monitor, sampled just after each rising edge.
    int         cyc = 0, rise_cyc = 0, lat = 0;
    int         pulse_n = 0, double_n = 0, onehot_bad = 0;
    int         pulse_cnt [4];
    logic [3:0] last_rdy = '0, prev_ch = '0;
    logic       prev_req = 1'b0, prev_rdy_in = 1'b0;
    logic [1:0] pulse_log [$];
    logic [1:0] grant_log [$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (adc_rdy && !prev_rdy_in) rise_cyc = cyc;
        prev_rdy_in = adc_rdy;
        if (adc_req && !prev_req) grant_log.push_back(grant_id);
        prev_req = adc_req;
        if (ch_rdy != 4'b0) begin
            pulse_log.push_back(grant_id);
            pulse_n++;
            last_rdy = ch_rdy;
            lat = cyc - rise_cyc;
            if (prev_ch != 4'b0) double_n++;
            if (ch_rdy != (4'b0001 << grant_id)) onehot_bad++;
            for (int b = 0; b < 4; b++) if (ch_rdy[b]) pulse_cnt[b]++;
        end
        prev_ch = ch_rdy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        pulse_log.delete();
        grant_log.delete();
        pulse_n = 0; double_n = 0; onehot_bad = 0;
        for (int b = 0; b < 4; b++) pulse_cnt[b] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_pulses(input string tag, input int n, input int budget);
        int c = 0;
        while (pulse_n < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_reached"}, (pulse_n >= n), 1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int c = 0;
        while (adc_req !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_adc_req_rise"}, adc_req, 1);
    endtask

    initial begin
        int hi_n;
        for (int b = 0; b < 4; b++) pulse_cnt[b] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ch_rdy", ch_rdy, 0);
        chk("rst_ch_dat", ch_dat, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_adc_req", adc_req, 0);
        chk("rst_err", err_timeout, 0);
        reset = 1'b0;
        clear_logs();

        // 1: single conversion on ch0
        ch_req = 4'b0001;
        wait_pulses("t1", 1, 60);
        ch_req = 4'b0000;
        chk("t1_ch_rdy", ch_rdy, 4'b0001);
        chk("t1_last_rdy", last_rdy, 4'b0001);
        chk("t1_ch_dat", ch_dat, 8'hA7);
        chk("t1_grant_id", grant_id, 0);
        chk("t1_adc_req_low", adc_req, 0);
        chk("t1_latency", lat, 3);
        @(negedge clk);
        chk("t1_pulse_width", ch_rdy, 0);
        repeat (10) @(negedge clk);
        chk("t1_idle", busy, 0);
        chk("t1_no_regrant", adc_req, 0);

        // 2: all four requesting, 8 conversions
        do_reset();
        ch_req = 4'b1111;
        model_dat = 8'h3C;
        wait_pulses("t2", 8, 400);
        ch_req = 4'b0000;
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_order%0d", i), (i < pulse_log.size()) ? pulse_log[i] : 2'bxx, i % 4);
        for (int b = 0; b < 4; b++)
            chk($sformatf("t2_count_ch%0d", b), pulse_cnt[b], 2);
        chk("t2_double", double_n, 0);
        chk("t2_onehot", onehot_bad, 0);
        chk("t2_ch_dat", ch_dat, 8'h3C);

        // 3: lone requester ch2, then ch0 joins
        do_reset();
        ch_req = 4'b0100;
        wait_pulses("t3a", 3, 200);
        ch_req = 4'b0101;
        wait_pulses("t3b", 5, 200);
        ch_req = 4'b0000;
        for (int i = 0; i < 3; i++)
            chk($sformatf("t3_lone%0d", i), (i < pulse_log.size()) ? pulse_log[i] : 2'bxx, 2);
        chk("t3_wrap_first", (pulse_log.size() > 3) ? pulse_log[3] : 2'bxx, 0);
        chk("t3_wrap_second", (pulse_log.size() > 4) ? pulse_log[4] : 2'bxx, 2);

        // 4: ch1 drops its request while granted
        repeat (10) @(negedge clk);
        clear_logs();
        ch_req = 4'b0010;
        wait_req("t4", 30);
        ch_req = 4'b0000;
        repeat (30) @(negedge clk);
        chk("t4_no_pulse", pulse_n, 0);
        chk("t4_granted_ch1", (grant_log.size() > 0) ? grant_log[0] : 2'bxx, 1);
        chk("t4_idle", busy, 0);
        ch_req = 4'b0110;
        wait_pulses("t4b", 1, 60);
        ch_req = 4'b0000;
        chk("t4_next_ch2", (pulse_log.size() > 0) ? pulse_log[0] : 2'bxx, 2);

        // 5: reset during GRANT with the ADC still showing ready
        repeat (10) @(negedge clk);
        adc_en = 1'b0;
        man_rdy = 1'b0;
        do_reset();
        ch_req = 4'b0001;
        wait_req("t5", 20);
        man_rdy = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_adc_req_async", adc_req, 0);
        chk("t5_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        hi_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (adc_req) hi_n++;
        end
        chk("t5_hold_off", hi_n, 0);
        chk("t5_no_pulse", pulse_n, 0);
        man_rdy = 1'b0;
        wait_req("t5b", 10);

        // 6: ADC never answers
`ifdef ADC_TIMEOUT_EN
        hi_n = 0;
        while (err_timeout !== 1'b1 && hi_n < 40) begin
            @(negedge clk);
            hi_n++;
        end
        chk("t6_cycles", hi_n, 11);
        chk("t6_err", err_timeout, 1);
        chk("t6_adc_req", adc_req, 0);
        chk("t6_no_pulse", pulse_n, 0);
`else
        repeat (30) @(negedge clk);
        chk("t6_adc_req_held", adc_req, 1);
        chk("t6_err", err_timeout, 0);
        chk("t6_busy", busy, 1);
        chk("t6_no_pulse", pulse_n, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
